// File: rtl/fe_ras_stack.sv
// Return-address stack for the fetch front end. Entry 0 is the top of the stack.
// Define FE_RAS_STACK_ERR_EN to add the sticky overflow_o/underflow_o flags.
module fe_ras_stack #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [XLEN-1:0]                data_i,
  output logic [XLEN-1:0]                data_o,
  output logic                           valid_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
`ifdef FE_RAS_STACK_ERR_EN
  ,
  output logic                           overflow_o,
  output logic                           underflow_o
`endif
);

  localparam int unsigned   CW   = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  addr_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_only, pop_only, empty;

  assign push_only = push_i & ~pop_i;
  assign pop_only  = pop_i & ~push_i;
  assign empty     = (count_q == '0);

  always_comb begin
    addr_d  = addr_q;
    valid_d = valid_q;
    count_d = count_q;
    if (flush_i) begin
      // Addresses are kept; only the valid bits are dropped.
      valid_d = '0;
      count_d = '0;
    end else if (push_i && pop_i) begin
      addr_d[0]  = data_i;
      valid_d[0] = 1'b1;
      if (empty) count_d = CW'(1);
    end else if (push_only) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        addr_d[k]  = addr_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      addr_d[0]  = data_i;
      valid_d[0] = 1'b1;
      if (count_q != FULL) count_d = count_q + 1'b1;
    end else if (pop_only && !empty) begin
      for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
        addr_d[k]  = addr_q[k+1];
        valid_d[k] = valid_q[k+1];
      end
      addr_d[DEPTH-1]  = '0;
      valid_d[DEPTH-1] = 1'b0;
      count_d          = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '{default: '0};
      valid_q <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign data_o  = addr_q[0];
  assign valid_o = valid_q[0];
  assign count_o = count_q;

`ifdef FE_RAS_STACK_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (flush_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (push_only && count_q == FULL) ovf_d = 1'b1;
      if (pop_only && empty)            unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
`endif

endmodule

// File: tb/tb_fe_ras_stack.sv
// Bench for fe_ras_stack: packed-vector stack model, per-cycle compare, directed
// literal cases and a randomized phase with occasional asynchronous resets.
module tb_fe_ras_stack;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
  logic [XLEN-1:0] data_i = '0;
  logic [XLEN-1:0] data_o;
  logic            valid_o;
  logic [CW-1:0]   count_o;
`ifdef FE_RAS_STACK_ERR_EN
  logic            overflow_o, underflow_o;
`endif

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  fe_ras_stack #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .push_i(push_i),
    .pop_i(pop_i), .data_i(data_i), .data_o(data_o), .valid_o(valid_o),
    .count_o(count_o)
`ifdef FE_RAS_STACK_ERR_EN
    , .overflow_o(overflow_o), .underflow_o(underflow_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Model: whole stack as one packed vector, top entry in the low bits.
  typedef struct packed {
    logic [DEPTH-1:0]      v;
    logic [DEPTH*XLEN-1:0] a;
    logic                  ov;
    logic                  un;
  } m_t;

  m_t m = '0;

  function automatic m_t step(input m_t s, input logic fl, input logic pu,
                              input logic po, input logic [XLEN-1:0] d);
    m_t n = s;
    int cnt = $countones(s.v);
    if (fl) begin
      n.v = '0; n.ov = 1'b0; n.un = 1'b0;
    end else if (pu && po) begin
      n.a[XLEN-1:0] = d; n.v[0] = 1'b1;
    end else if (pu) begin
      if (cnt == DEPTH) n.ov = 1'b1;
      n.a = (s.a << XLEN) | (DEPTH*XLEN)'(d);
      n.v = (s.v << 1) | DEPTH'(1);
    end else if (po) begin
      if (cnt == 0) n.un = 1'b1;
      else begin
        n.a = s.a >> XLEN;
        n.v = s.v >> 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) m <= '0;
    else         m <= step(m, flush_i, push_i, pop_i, data_i);
  end

  function automatic logic [XLEN-1:0] m_data();
    return m.a[XLEN-1:0];
  endfunction
  function automatic int m_count();
    return $countones(m.v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("cyc_data",  64'(data_o),  64'(m_data()));
      chk("cyc_valid", 64'(valid_o), 64'(m.v[0]));
      chk("cyc_count", 64'(count_o), 64'(m_count()));
`ifdef FE_RAS_STACK_ERR_EN
      chk("cyc_ovf", 64'(overflow_o),  64'(m.ov));
      chk("cyc_unf", 64'(underflow_o), 64'(m.un));
`endif
    end
  end

  // Hand-computed expectations checked against both the DUT and the model.
  task automatic lit(input string nm, input logic [XLEN-1:0] d, input logic v, input int c);
    chk({nm, "_data"},  64'(data_o),    64'(d));
    chk({nm, "_valid"}, 64'(valid_o),   64'(v));
    chk({nm, "_count"}, 64'(count_o),   64'(c));
    chk({nm, "_mdata"}, 64'(m_data()),  64'(d));
    chk({nm, "_mcnt"},  64'(m_count()), 64'(c));
  endtask

  task automatic flags(input string nm, input logic ov, input logic un);
`ifdef FE_RAS_STACK_ERR_EN
    chk({nm, "_ovf"}, 64'(overflow_o),  64'(ov));
    chk({nm, "_unf"}, 64'(underflow_o), 64'(un));
    chk({nm, "_movf"}, 64'(m.ov), 64'(ov));
`else
    if (ov === 1'bx || un === 1'bx) $display("flags unknown for %s", nm);
`endif
  endtask

  task automatic op(input logic fl, input logic pu, input logic po, input logic [XLEN-1:0] d);
    @(negedge clk_i);
    flush_i = fl; push_i = pu; pop_i = po; data_i = d;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
  endtask

  initial begin
    cmp_en = 1'b1;
    repeat (2) @(negedge clk_i);
    lit("reset", '0, 1'b0, 0);
    flags("reset", 1'b0, 1'b0);
    rst_ni = 1'b1;

    op(0, 1, 0, 32'h100); op(0, 1, 0, 32'h200);
    lit("push2", 32'h200, 1'b1, 2);
    op(0, 0, 1, '0); lit("pop1", 32'h100, 1'b1, 1);
    op(0, 0, 1, '0); lit("pop2", 32'h0, 1'b0, 0);

    op(1, 0, 0, '0);
    op(0, 1, 0, 32'h100); op(0, 1, 0, 32'h200); op(0, 1, 0, 32'h300);
    lit("ovf_push", 32'h300, 1'b1, 2);
    op(0, 0, 1, '0); lit("ovf_pop1", 32'h200, 1'b1, 1);
    op(0, 0, 1, '0); lit("ovf_pop2", 32'h0, 1'b0, 0);
    flags("ovf", 1'b1, 1'b0);

    op(1, 0, 0, '0);
    flags("flush_clr", 1'b0, 1'b0);
    op(0, 1, 0, 32'h100); op(0, 1, 0, 32'h200);
    op(0, 1, 1, 32'h400); lit("pushpop", 32'h400, 1'b1, 2);
    op(0, 0, 1, '0); lit("pushpop_next", 32'h100, 1'b1, 1);
    op(0, 0, 1, '0); lit("pushpop_empty", 32'h0, 1'b0, 0);
    op(0, 1, 1, 32'h7); lit("pushpop_on_empty", 32'h7, 1'b1, 1);

    op(1, 0, 0, '0);
    op(0, 1, 0, 32'h100); op(0, 1, 0, 32'h200);
    op(1, 1, 0, 32'h500); lit("flush_prio", 32'h200, 1'b0, 0);

    op(0, 0, 1, '0); lit("underflow", 32'h200, 1'b0, 0);
    flags("unf", 1'b0, 1'b1);
    op(0, 0, 0, '0); flags("unf_sticky", 1'b0, 1'b1);
    op(1, 0, 0, '0); flags("unf_flush", 1'b0, 1'b0);
    lit("after_flush", 32'h200, 1'b0, 0);

    op(0, 1, 0, 32'hABC); lit("pre_rst", 32'hABC, 1'b1, 1);
    #2 rst_ni = 1'b0;
    #1 lit("async_rst", '0, 1'b0, 0);
    flags("async_rst", 1'b0, 1'b0);
    @(negedge clk_i); rst_ni = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      if (!rst_ni) rst_ni = 1'b1;
      flush_i = ($urandom_range(0, 15) == 0);
      push_i  = $urandom_range(0, 1) == 1;
      pop_i   = $urandom_range(0, 1) == 1;
      data_i  = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_ni = 1'b0;
      end
    end
    @(negedge clk_i);
    rst_ni = 1'b1; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
    repeat (2) @(negedge clk_i);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
